// File: rtl/vga_scan_controller.sv
// 640x480@60 style VGA timing generator: pixel-rate enable from clk/2, x/y scan
// counters, and a registered colour/sync stage aligned one pixel behind x,y.
module vga_scan_controller #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter logic [23:0] FG_RGB   = 24'hFFFFFF,
  parameter logic [23:0] BG_RGB   = 24'h000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pixel,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       vga_clk,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_ON  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_OFF = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_ON  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic        pix_en_r;
  logic [9:0]  h_cnt_r;
  logic [9:0]  v_cnt_r;
  logic [9:0]  h_nxt_s;
  logic [9:0]  v_nxt_s;
  logic        h_wrap_s;
  logic        v_wrap_s;
  logic        frame_nxt_s;
  logic        visible_s;
  logic        hsync_raw_s;
  logic        vsync_raw_s;
  logic [23:0] rgb_s;
  logic [23:0] rgb_r;
  logic        hsync_r;
  logic        vsync_r;
  logic        blank_n_r;
  logic        frame_start_r;

  // Pixel-rate enable: toggles every clk, so it is high on every second edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_en_r <= 1'b0;
    end else begin
      pix_en_r <= ~pix_en_r;
    end
  end

  assign h_wrap_s    = (h_cnt_r == H_LAST);
  assign v_wrap_s    = (v_cnt_r == V_LAST);
  assign frame_nxt_s = pix_en_r & h_wrap_s & v_wrap_s;

  // Next scan position; the line counter only moves when the pixel counter wraps.
  always_comb begin
    h_nxt_s = h_cnt_r;
    v_nxt_s = v_cnt_r;
    if (pix_en_r) begin
      if (h_wrap_s) begin
        h_nxt_s = 10'd0;
        if (v_wrap_s) begin
          v_nxt_s = 10'd0;
        end else begin
          v_nxt_s = v_cnt_r + 10'd1;
        end
      end else begin
        h_nxt_s = h_cnt_r + 10'd1;
      end
    end else begin
      h_nxt_s = h_cnt_r;
      v_nxt_s = v_cnt_r;
    end
  end

  // Scan counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_r <= 10'd0;
      v_cnt_r <= 10'd0;
    end else begin
      h_cnt_r <= h_nxt_s;
      v_cnt_r <= v_nxt_s;
    end
  end

  // Colour and raw sync for the position currently on x,y.
  always_comb begin
    visible_s   = (h_cnt_r < H_VIS) && (v_cnt_r < V_VIS);
    hsync_raw_s = !((h_cnt_r >= H_SYNC_ON) && (h_cnt_r < H_SYNC_OFF));
    vsync_raw_s = !((v_cnt_r >= V_SYNC_ON) && (v_cnt_r < V_SYNC_OFF));
    if (!visible_s) begin
      rgb_s = 24'h000000;
    end else if (pixel) begin
      rgb_s = FG_RGB;
    end else begin
      rgb_s = BG_RGB;
    end
  end

  // Output stage: sampled together on pix_en so sync, blank and colour share one delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_r     <= 24'h000000;
      hsync_r   <= 1'b1;
      vsync_r   <= 1'b1;
      blank_n_r <= 1'b0;
    end else if (pix_en_r) begin
      rgb_r     <= rgb_s;
      hsync_r   <= hsync_raw_s;
      vsync_r   <= vsync_raw_s;
      blank_n_r <= visible_s;
    end else begin
      rgb_r     <= rgb_r;
      hsync_r   <= hsync_r;
      vsync_r   <= vsync_r;
      blank_n_r <= blank_n_r;
    end
  end

  // Frame pulse only on the wrap into (0,0), never on reset exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= frame_nxt_s;
    end
  end

  assign x           = h_cnt_r;
  assign y           = v_cnt_r;
  assign vga_clk     = pix_en_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign blank_n     = blank_n_r;
  assign red         = rgb_r[23:16];
  assign green       = rgb_r[15:8];
  assign blue        = rgb_r[7:0];
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Scoreboard bench: a small-timing DUT checked every clk against a bench model,
// plus a default-timing DUT checked at hand-computed points on its first line.
module tb_vga_scan_controller;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;   // 15
  localparam int VT = VA + VF + VS + VB;   // 8
  localparam int FRAME_PIX = HT * VT;      // 120 pixels = 240 clks

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pixel = 1'b0;
  logic [9:0] x, y;
  logic       vga_clk, hsync, vsync, blank_n, frame_start;
  logic [7:0] red, green, blue;

  logic       pixel_d = 1'b1;
  logic [9:0] d_x, d_y;
  logic       d_vga_clk, d_hsync, d_vsync, d_blank_n, d_frame_start;
  logic [7:0] d_red, d_green, d_blue;

  always #5 clk = ~clk;

  vga_scan_controller #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst), .pixel(pixel), .x(x), .y(y), .vga_clk(vga_clk),
    .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .red(red), .green(green),
    .blue(blue), .frame_start(frame_start)
  );

  vga_scan_controller dut_def (
    .clk(clk), .rst(rst), .pixel(pixel_d), .x(d_x), .y(d_y), .vga_clk(d_vga_clk),
    .hsync(d_hsync), .vsync(d_vsync), .blank_n(d_blank_n), .red(d_red), .green(d_green),
    .blue(d_blue), .frame_start(d_frame_start)
  );

  typedef struct {
    int          ex;
    int          ey;
    logic        vc;
    logic        hs;
    logic        vs;
    logic        bl;
    logic        fs;
    logic [23:0] rgb;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   fs_seen  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_x"}, 32'(x), 32'd0);
    chk({tag, "_y"}, 32'(y), 32'd0);
    chk({tag, "_vga_clk"}, 32'(vga_clk), 32'd0);
    chk({tag, "_hsync"}, 32'(hsync), 32'd1);
    chk({tag, "_vsync"}, 32'(vsync), 32'd1);
    chk({tag, "_blank_n"}, 32'(blank_n), 32'd0);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, "_rgb"}, 32'({red, green, blue}), 32'd0);
  endtask

  // Pixel pattern: mode 0 cycles per frame through solid / x[0] / random; mode 1 is x[0].
  function automatic logic pat(input int n, input int mode);
    int xx;
    xx = n % HT;
    if (mode == 1) return xx[0];
    case ((n / FRAME_PIX) % 3)
      0:       return 1'b1;
      1:       return xx[0];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Expected state after edge e following reset release; p is the pixel of index n-1.
  function automatic exp_t model(input int e, input logic p);
    exp_t r;
    int   n, m, mx, my;
    logic vis;
    n    = e / 2;
    r.ex = n % HT;
    r.ey = (n / HT) % VT;
    r.vc = 1'(e % 2);
    r.fs = (e % 2 == 0) && (n > 0) && (n % FRAME_PIX == 0);
    if (n == 0) begin
      r.hs = 1'b1; r.vs = 1'b1; r.bl = 1'b0; r.rgb = 24'h0;
    end else begin
      m    = n - 1;
      mx   = m % HT;
      my   = (m / HT) % VT;
      vis  = (mx < HA) && (my < VA);
      r.bl = vis;
      r.hs = !((mx >= HA + HF) && (mx < HA + HF + HS));
      r.vs = !((my >= VA + VF) && (my < VA + VF + VS));
      r.rgb = vis ? (p ? 24'hFFFFFF : 24'h000000) : 24'h000000;
    end
    return r;
  endfunction

  // Releases reset mid-cycle and pushes one expected record per clk.
  task automatic run_phase(input int edges, input int mode);
    logic cur_pix, prev_pix;
    cur_pix  = pat(0, mode);
    prev_pix = 1'b0;
    pixel    = cur_pix;
    rst      = 1'b0;
    for (int e = 1; e <= edges; e++) begin
      @(posedge clk);
      #1;
      if (e % 2 == 0) begin
        prev_pix = cur_pix;
        cur_pix  = pat(e / 2, mode);
        pixel    = cur_pix;
      end
      sb_q.push_back(model(e, prev_pix));
    end
  endtask

  // Default-timing instance: hand-computed points on line 0 (outputs lag x by 2 clks).
  task automatic def_check();
    for (int e = 1; e <= 1600; e++) begin
      @(posedge clk);
      #1;
      case (e)
        1280: begin
          chk("def_blank_last_vis", 32'(d_blank_n), 32'd1);
          chk("def_rgb_last_vis", 32'({d_red, d_green, d_blue}), 32'hFFFFFF);
        end
        1282: begin
          chk("def_blank_first_hidden", 32'(d_blank_n), 32'd0);
          chk("def_rgb_first_hidden", 32'({d_red, d_green, d_blue}), 32'h0);
        end
        1313: chk("def_hsync_before", 32'(d_hsync), 32'd1);
        1314: chk("def_hsync_start", 32'(d_hsync), 32'd0);
        1505: chk("def_hsync_end", 32'(d_hsync), 32'd0);
        1506: chk("def_hsync_after", 32'(d_hsync), 32'd1);
        1599: begin
          chk("def_x_last", 32'(d_x), 32'd799);
          chk("def_y_line0", 32'(d_y), 32'd0);
        end
        1600: begin
          chk("def_x_wrap", 32'(d_x), 32'd0);
          chk("def_y_line1", 32'(d_y), 32'd1);
          chk("def_vsync_idle", 32'(d_vsync), 32'd1);
          chk("def_no_frame_start", 32'(d_frame_start), 32'd0);
        end
        default: ;
      endcase
    end
  endtask

  // Monitor: pops the expected record for this clk and compares on the falling edge.
  always @(negedge clk) begin
    exp_t ex;
    if (!rst && frame_start === 1'b1) fs_seen++;
    if (sb_q.size() > 0) begin
      ex = sb_q.pop_front();
      chk("x", 32'(x), 32'(ex.ex));
      chk("y", 32'(y), 32'(ex.ey));
      chk("vga_clk", 32'(vga_clk), 32'(ex.vc));
      chk("hsync", 32'(hsync), 32'(ex.hs));
      chk("vsync", 32'(vsync), 32'(ex.vs));
      chk("blank_n", 32'(blank_n), 32'(ex.bl));
      chk("frame_start", 32'(frame_start), 32'(ex.fs));
      chk("rgb", 32'({red, green, blue}), 32'(ex.rgb));
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk_reset("reset_hold");

    // Phase A: ~7 small frames from reset; the default instance runs its first line alongside.
    @(negedge clk);
    #2;
    fs_seen = 0;
    fork
      run_phase(1700, 0);
      def_check();
    join
    @(negedge clk);
    #2;
    chk("frame_count_a", 32'(fs_seen), 32'd7);

    // Reset in the middle of a line; then resume.
    rst = 1'b1;
    #1;
    chk_reset("reset_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    run_phase(82, 1);
    @(negedge clk);
    #2;
    chk("hsync_before_abort", 32'(hsync), 32'd0);
    chk("x_before_abort", 32'(x), 32'd11);
    rst = 1'b1;
    #1;
    chk_reset("reset_mid_sync");
    repeat (3) @(posedge clk);
    chk_reset("reset_mid_hold");

    // Phase C: two frames after the abort, frame_start exactly twice.
    @(negedge clk);
    #2;
    fs_seen = 0;
    run_phase(500, 0);
    @(negedge clk);
    #2;
    chk("frame_count_c", 32'(fs_seen), 32'd2);
    chk("queue_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
